fpga_config_loader: RTL and testbench

- Serial bitstream loader that produces the fabric's parallel configuration selects: brbselect, leftioselect, rightioselect, topioselect and bottomioselect.
- These feed the routing blocks (last_row_routing and the rest of the brb array) and the io_block instances.
- Accepts a framed serial stream over a valid/ready handshake and assembles it in a shadow register.
- Commits the shadow register atomically, so the fabric never sees a partially loaded configuration.

---
 rtl/fpga_cfg_pkg.sv | 17 +
 rtl/cfg_crc8.sv | 29 ++
 rtl/fpga_config_loader.sv | 175 +++++++++++++++++
 tb/tb_fpga_config_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared constants and FSM state type for the fabric configuration loader.
package fpga_cfg_pkg;

    localparam logic [7:0] SYNC_WORD = 8'hA5;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam int         BRB_W_DEF = 900;
    localparam int         IO_W_DEF  = 30;
    localparam int         TOTAL_DEF = BRB_W_DEF + 4 * IO_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC,
        COMMIT
    } cfg_state_t;

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 (poly 0x07, init 0, MSB-first, no reflection, no final XOR).
// Exists only when FPGA_CFG_CRC_EN is defined.
`ifdef FPGA_CFG_CRC_EN
module cfg_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb;
    assign fb = crc[7] ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end

endmodule
`endif

// File: rtl/fpga_config_loader.sv
// Framed serial loader for the fabric select vectors with atomic commit.
// Optional CRC-8 trailer check enabled by defining FPGA_CFG_CRC_EN.
//
// state   | meaning
// IDLE    | hunting for the sync word in the serial stream
// PAYLOAD | shifting TOTAL configuration bits into the shadow register
// CRC     | receiving the 8-bit trailer (FPGA_CFG_CRC_EN only)
// COMMIT  | one cycle; selects load from shadow at its end
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int         BRB_W = BRB_W_DEF,
    parameter int         IO_W  = IO_W_DEF,
    parameter logic [7:0] SYNC  = SYNC_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic             cfg_data,
    output logic             cfg_ready,
    input  logic             cfg_abort,
    output logic [BRB_W-1:0] brbselect,
    output logic [IO_W-1:0]  leftioselect,
    output logic [IO_W-1:0]  rightioselect,
    output logic [IO_W-1:0]  topioselect,
    output logic [IO_W-1:0]  bottomioselect,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_error
);

    localparam int            TOTAL = BRB_W + 4 * IO_W;
    localparam int            CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

    cfg_state_t       state, state_nxt;
    logic [TOTAL-1:0] shadow;
    logic [7:0]       sync_sr;
    logic [CW-1:0]    cnt;
    logic             accept, sync_hit, last_bit;

    assign cfg_ready = (state != COMMIT);
    assign cfg_busy  = (state != IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign sync_hit  = ({sync_sr[6:0], cfg_data} == SYNC);
    assign last_bit  = (cnt == LAST);

`ifdef FPGA_CFG_CRC_EN
    logic [7:0] trl, crc;
    logic       crc_ok, err_q;

    assign crc_ok    = ({trl[6:0], cfg_data} == crc);
    assign cfg_error = err_q;

    cfg_crc8 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE && accept && !cfg_abort && sync_hit),
        .en  (state == PAYLOAD && accept && !cfg_abort),
        .din (cfg_data),
        .crc (crc)
    );
`else
    assign cfg_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort outranks a simultaneous accept in every receiving state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !cfg_abort && sync_hit) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (cfg_abort) begin
                    state_nxt = IDLE;
                end else if (accept && last_bit) begin
`ifdef FPGA_CFG_CRC_EN
                    state_nxt = CRC;
`else
                    state_nxt = COMMIT;
`endif
                end
            end
            CRC: begin
`ifdef FPGA_CFG_CRC_EN
                if (cfg_abort) begin
                    state_nxt = IDLE;
                end else if (accept && cnt == CW'(7)) begin
                    state_nxt = crc_ok ? COMMIT : IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow         <= '0;
            sync_sr        <= '0;
            cnt            <= '0;
            brbselect      <= '0;
            leftioselect   <= '0;
            rightioselect  <= '0;
            topioselect    <= '0;
            bottomioselect <= '0;
            cfg_done       <= 1'b0;
`ifdef FPGA_CFG_CRC_EN
            trl            <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_abort) begin
                        sync_sr <= '0;
                    end else if (accept) begin
                        // Clearing on a hit keeps a stale tail from faking the next sync.
                        if (sync_hit) begin
                            sync_sr  <= '0;
                            cnt      <= '0;
                            cfg_done <= 1'b0;
`ifdef FPGA_CFG_CRC_EN
                            err_q    <= 1'b0;
`endif
                        end else begin
                            sync_sr <= {sync_sr[6:0], cfg_data};
                        end
                    end
                end
                PAYLOAD: begin
                    if (cfg_abort) begin
                        sync_sr <= '0;
                    end else if (accept) begin
                        shadow <= {cfg_data, shadow[TOTAL-1:1]};
                        cnt    <= last_bit ? '0 : cnt + CW'(1);
                    end
                end
`ifdef FPGA_CFG_CRC_EN
                CRC: begin
                    if (cfg_abort) begin
                        sync_sr <= '0;
                    end else if (accept) begin
                        trl <= {trl[6:0], cfg_data};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(7) && !crc_ok) err_q <= 1'b1;
                    end
                end
`endif
                COMMIT: begin
                    brbselect      <= shadow[BRB_W-1:0];
                    leftioselect   <= shadow[BRB_W +: IO_W];
                    rightioselect  <= shadow[BRB_W + IO_W +: IO_W];
                    topioselect    <= shadow[BRB_W + 2 * IO_W +: IO_W];
                    bottomioselect <= shadow[BRB_W + 3 * IO_W +: IO_W];
                    cfg_done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader; follows FPGA_CFG_CRC_EN if defined.
module tb_fpga_config_loader;

    localparam int BRB   = 900;
    localparam int IO    = 30;
    localparam int TOTAL = BRB + 4 * IO;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_valid = 1'b0;
    logic cfg_data = 1'b0;
    logic cfg_abort = 1'b0;
    logic cfg_ready, cfg_busy, cfg_done, cfg_error;
    logic [BRB-1:0] brbselect;
    logic [IO-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;
    logic [TOTAL-1:0] outv;

    int errors = 0;
    int checks = 0;
    int commits = 0;
    logic [TOTAL-1:0] sbq[$];
    logic [TOTAL-1:0] last_exp = '0;
    logic done_d = 1'b0;

    assign outv = {bottomioselect, topioselect, rightioselect, leftioselect, brbselect};

    fpga_config_loader dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_data       (cfg_data),
        .cfg_ready      (cfg_ready),
        .cfg_abort      (cfg_abort),
        .brbselect      (brbselect),
        .leftioselect   (leftioselect),
        .rightioselect  (rightioselect),
        .topioselect    (topioselect),
        .bottomioselect (bottomioselect),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .cfg_error      (cfg_error)
    );

    always #5 clk = ~clk;

`ifdef FPGA_CFG_CRC_EN
    function automatic logic [7:0] crc8(input logic [TOTAL-1:0] p);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < TOTAL; i++) begin
            fb = c[7] ^ p[i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    // Commit monitor: every rising cfg_done pops one expected image.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cfg_done && !done_d) begin
                commits++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL commit_unexpected commit#=%0d queued=0", commits);
                end else begin
                    last_exp = sbq.pop_front();
                    if (outv !== last_exp) begin
                        errors++;
                        $display("FAIL commit_data got_ones=%0d need_ones=%0d diff_ones=%0d",
                                 $countones(outv), $countones(last_exp), $countones(outv ^ last_exp));
                    end
                end
            end
            done_d = cfg_done;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time=%0t", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, input logic ab, output int waited);
        cfg_valid = 1'b1;
        cfg_data  = b;
        cfg_abort = ab;
        waited = 0;
        while (!cfg_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!cfg_ready) begin
            errors++;
            $display("FAIL ready_timeout got=0 need=1");
        end
        @(negedge clk);
        cfg_abort = 1'b0;
    endtask

    task automatic send_frame(input logic [TOTAL-1:0] p, input bit stall, input bit bad,
                              input int abort_at, output int first_wait);
        logic [7:0] sw;
        int w;
`ifdef FPGA_CFG_CRC_EN
        logic [7:0] c;
`endif
        sw = 8'hA5;
        first_wait = 0;
        if (abort_at < 0 && !bad) sbq.push_back(p);
        for (int k = 7; k >= 0; k--) begin
            send_bit(sw[k], 1'b0, w);
            if (k == 7) first_wait = w;
        end
        for (int i = 0; i < TOTAL; i++) begin
            if (i == abort_at) begin
                send_bit(p[i], 1'b1, w);
                cfg_valid = 1'b0;
                return;
            end
            send_bit(p[i], 1'b0, w);
            if (stall && (i % 100) == 99) begin
                cfg_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
`ifdef FPGA_CFG_CRC_EN
        c = crc8(p);
        if (bad) c[0] = ~c[0];
        for (int k = 7; k >= 0; k--) send_bit(c[k], 1'b0, w);
`endif
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks += 5;
        if (outv !== '0) begin errors++; $display("FAIL rst_selects got_ones=%0d need=0", $countones(outv)); end
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b need=0", cfg_busy); end
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b need=1", cfg_ready); end
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b need=0", cfg_done); end
        if (cfg_error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b need=0", cfg_error); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [TOTAL-1:0] p;
        int fw;
        p = '0;
        p[5] = 1'b1; p[900] = 1'b1; p[991] = 1'b1;
        send_frame(p, 1'b0, 1'b0, -1, fw);
        checks += 2;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL basic_commit_ready got=%b need=0", cfg_ready); end
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL basic_done_early got=%b need=0", cfg_done); end
        @(negedge clk);
        checks += 5;
        if (cfg_done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b need=1", cfg_done); end
        if (brbselect[5] !== 1'b1) begin errors++; $display("FAIL basic_brb5 got=%b need=1", brbselect[5]); end
        if (leftioselect[0] !== 1'b1) begin errors++; $display("FAIL basic_left0 got=%b need=1", leftioselect[0]); end
        if (bottomioselect[1] !== 1'b1) begin errors++; $display("FAIL basic_bot1 got=%b need=1", bottomioselect[1]); end
        if ($countones(outv) != 3) begin errors++; $display("FAIL basic_ones got=%0d need=3", $countones(outv)); end
    endtask

    task automatic test_stall_sync;
        logic [TOTAL-1:0] p;
        logic [7:0] sw;
        int fw;
        p = '0;
        p[5] = 1'b1; p[900] = 1'b1; p[991] = 1'b1;
        sw = 8'hA5;
        for (int k = 0; k < 8; k++) p[300 + k] = sw[7 - k];
        send_frame(p, 1'b1, 1'b0, -1, fw);
        checks++;
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL stall_done_early got=%b need=0", cfg_done); end
        @(negedge clk);
        checks += 2;
        if (cfg_done !== 1'b1) begin errors++; $display("FAIL stall_done got=%b need=1", cfg_done); end
        if (outv !== p) begin errors++; $display("FAIL stall_data got_ones=%0d need_ones=%0d", $countones(outv), $countones(p)); end
    endtask

`ifdef FPGA_CFG_CRC_EN
    task automatic test_crc_error;
        logic [TOTAL-1:0] p;
        int fw;
        p = '0;
        p[7] = 1'b1;
        send_frame(p, 1'b0, 1'b1, -1, fw);
        checks += 5;
        if (cfg_error !== 1'b1) begin errors++; $display("FAIL crc_error got=%b need=1", cfg_error); end
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL crc_done got=%b need=0", cfg_done); end
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL crc_busy got=%b need=0", cfg_busy); end
        if (brbselect[5] !== 1'b1) begin errors++; $display("FAIL crc_brb5 got=%b need=1", brbselect[5]); end
        if (outv !== last_exp) begin errors++; $display("FAIL crc_retain got_ones=%0d need_ones=%0d", $countones(outv), $countones(last_exp)); end
        repeat (3) @(negedge clk);
        checks += 2;
        if (cfg_error !== 1'b1) begin errors++; $display("FAIL crc_sticky got=%b need=1", cfg_error); end
        if (outv !== last_exp) begin errors++; $display("FAIL crc_retain2 got_ones=%0d need_ones=%0d", $countones(outv), $countones(last_exp)); end
    endtask
`endif

    task automatic test_abort;
        logic [TOTAL-1:0] p;
        logic [BRB-1:0] eb;
        int fw;
        p = '0;
        p[7] = 1'b1;
        p[600] = 1'b1;
        send_frame(p, 1'b0, 1'b0, 500, fw);
        checks += 4;
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b need=0", cfg_busy); end
        if (outv !== last_exp) begin errors++; $display("FAIL abort_retain got_ones=%0d need_ones=%0d", $countones(outv), $countones(last_exp)); end
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b need=0", cfg_done); end
        if (cfg_error !== 1'b0) begin errors++; $display("FAIL abort_error got=%b need=0", cfg_error); end
        repeat (4) @(negedge clk);
        p = '0;
        p[7] = 1'b1;
        send_frame(p, 1'b0, 1'b0, -1, fw);
        @(negedge clk);
        eb = '0;
        eb[7] = 1'b1;
        checks += 3;
        if (cfg_done !== 1'b1) begin errors++; $display("FAIL abort_next_done got=%b need=1", cfg_done); end
        if (brbselect !== eb) begin errors++; $display("FAIL abort_next_brb got_ones=%0d need_ones=1", $countones(brbselect)); end
        if ($countones(outv) != 1) begin errors++; $display("FAIL abort_next_ones got=%0d need=1", $countones(outv)); end
    endtask

    task automatic test_back_to_back;
        logic [TOTAL-1:0] a, b;
        int fwa, fwb, c0;
        a = '0; a[1] = 1'b1; a[1019] = 1'b1; a[930] = 1'b1;
        b = '0; b[0] = 1'b1; b[512] = 1'b1; b[960] = 1'b1;
        c0 = commits;
        send_frame(a, 1'b0, 1'b0, -1, fwa);
        send_frame(b, 1'b0, 1'b0, -1, fwb);
        @(negedge clk);
        checks += 4;
        if (fwb != 1) begin errors++; $display("FAIL b2b_first_wait got=%0d need=1", fwb); end
        if (commits != c0 + 2) begin errors++; $display("FAIL b2b_commits got=%0d need=%0d", commits - c0, 2); end
        if (outv !== b) begin errors++; $display("FAIL b2b_data got_ones=%0d need_ones=%0d", $countones(outv), $countones(b)); end
        if (cfg_done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b need=1", cfg_done); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] sw;
        int w;
        sw = 8'hA5;
        for (int k = 7; k >= 0; k--) send_bit(sw[k], 1'b0, w);
        for (int i = 0; i < 50; i++) send_bit(i[0], 1'b0, w);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b need=1", cfg_busy); end
        #3;
        rst = 1'b1;
        #1;
        checks += 4;
        if (outv !== '0) begin errors++; $display("FAIL mid_selects got_ones=%0d need=0", $countones(outv)); end
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b need=0", cfg_busy); end
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b need=1", cfg_ready); end
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b need=0", cfg_done); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b need=0", cfg_busy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall_sync;
`ifdef FPGA_CFG_CRC_EN
        test_crc_error;
`endif
        test_abort;
        test_back_to_back;
        test_reset_midframe;
        repeat (5) @(negedge clk);
        checks += 2;
        if (sbq.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d need=0", sbq.size()); end
        if (commits != 5) begin errors++; $display("FAIL commit_count got=%0d need=5", commits); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
